lfsr_checker: RTL and testbench
===============================

Name: lfsr_checker

Overview:
- Receiving end of the 32-bit PRBS produced by the team's LFSR generator. Consumes the serial bit stream (the new bit 0 of the generator each step) and self-synchronises to it.
- Once synchronised, flywheels the sequence locally and counts bit errors.
- Used on loopback/link-test paths to qualify data integrity.

Parameters:
- SYNC_BITS, 64, consecutive correct predictions required in VERIFY before LOCKED.
- WINDOW, 256, valid beats per error-monitoring window in LOCKED.
- LOSS_THRESH, 16, errors within one window that force loss of lock (1..WINDOW).
- CNT_W, 16, width of err_count_o.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  asynchronous active-low reset.
- bit_i  in  1  received PRBS bit.
- valid_i  in  1  bit_i valid this cycle; all state frozen when low.
- clear_i  in  1  synchronous clear of err_count_o.
- locked_o  out  1  registered; high while in LOCKED.
- err_o  out  1  one-cycle pulse, beat in LOCKED mismatched.
- lock_lost_o  out  1  one-cycle pulse on LOCKED->HUNT.
- err_count_o  out  CNT_W  saturating count of mismatches seen in LOCKED.

Behaviour:
- Clock and reset: one clock, clk_i. reset_ni is asynchronous, active-low.
- Feedback function: f(s) = s[27]^s[23]^s[19]^s[18]^s[15]^s[11]^s[7]^s[4]^s[1]. Generator step: s <= {s[30:0], f(s)}. Stream bit = f(previous state).
- Internal registers: r[31:0] prediction state, fill counter, match counter, window beat counter, window error counter.
- Reset (reset_ni low, async): state HUNT; r=0; all counters 0; every output 0.
- HUNT, per valid beat:
  - r <= {r[30:0], bit_i}; fill++.
  - On the 32nd beat: go VERIFY if the shifted-in r != 0. If r == 0 (all-zero lockup), restart fill at 0 and stay in HUNT.
- VERIFY, per valid beat:
  - e = f(r); r <= {r[30:0], e}.
  - bit_i == e: match++. On the SYNC_BITS-th match, go LOCKED.
  - bit_i != e: go HUNT, fill=0, match=0.
  - No err_o and no counting in this state.
- LOCKED, per valid beat:
  - e = f(r); r <= {r[30:0], e}. This is the flywheel: r always uses the predicted bit, never bit_i, so one error does not propagate.
  - Mismatch: err_o pulses the next cycle; err_count_o increments, saturating at all-ones; window error counter increments.
  - If the window error count including this beat reaches LOSS_THRESH: next cycle state is HUNT, lock_lost_o pulses, locked_o drops, fill/match/window counters clear. err_count_o is retained.
  - Otherwise, on the WINDOW-th beat of a window, both window counters clear.
  - If loss and window end coincide, loss wins.
- Latency: locked_o rises the cycle after the beat that completes VERIFY. err_o and err_count_o update the cycle after the offending beat.
- valid_i low: no state, counter or r change; err_o and lock_lost_o are 0.
- clear_i: err_count_o <= 0. If an increment occurs in the same cycle, clear wins and the increment is dropped.
- Reset mid-operation: immediate return to the reset values above, regardless of state.
- Clean-stream lock time: 32 + SYNC_BITS valid beats.

Optional Feature:
- Macro: LFSR_CHECKER_BER_EN.
- Defined:
  - Adds output bit_count_o, out, 32 bits: counts valid beats spent in LOCKED, saturating at 2^32-1.
  - Cleared by clear_i under the same priority rule as err_count_o; reset value 0.
  - Enables BER = err_count_o / bit_count_o.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset, then drive 96 clean generator bits (generator reset seed 123456789), valid_i=1 every cycle -> locked_o=1 from the cycle after beat 96; err_count_o=0; err_o never pulses.
- Locked; invert one bit -> err_o single pulse next cycle; err_count_o=1; locked_o stays 1; the following 300 clean beats give no further errors.
- Locked; invert 16 bits within one 256-beat window -> lock_lost_o pulse and locked_o=0 the cycle after the 16th error; err_count_o=16; 96 further clean beats re-lock.
- Locked; 15 errors in window 1 and 15 in window 2 -> no loss of lock; err_count_o=30.
- bit_i=0 constant for 200 beats from reset -> stays HUNT, locked_o=0 throughout. Separately, valid_i toggling every other cycle with a clean stream -> lock after exactly 96 valid beats (192 cycles).
- CNT_W=4 with 20 errors -> err_count_o saturates at 15. clear_i asserted on an error beat -> err_count_o=0 next cycle. reset_ni pulsed low while LOCKED -> all outputs 0 immediately.

Source files
------------

// File: rtl/lfsr_checker.sv
// ---------------------------------------------------------------------------
// lfsr_checker
//
// Receive-side checker for the 32-bit PRBS produced by the LFSR generator.
// It hunts for sync by loading 32 received bits into its own prediction
// register, verifies SYNC_BITS consecutive predictions, then flywheels the
// sequence locally and counts bit errors.  Too many errors inside one
// monitoring window drop it back to hunting.
//
// Feedback:  f(s) = s[27]^s[23]^s[19]^s[18]^s[15]^s[11]^s[7]^s[4]^s[1]
// Generator: s <= {s[30:0], f(s)}; the stream bit is f(previous state).
//
// Parameters:
//   SYNC_BITS    consecutive correct predictions needed to lock
//   WINDOW       valid beats per error-monitoring window while locked
//   LOSS_THRESH  errors inside one window that force loss of lock
//   CNT_W        width of err_count_o
//
// Ports:
//   clk_i        clock
//   reset_ni     asynchronous active-low reset
//   bit_i        received PRBS bit
//   valid_i      bit_i valid this cycle; all state frozen when low
//   clear_i      synchronous clear of the error (and bit) counters
//   locked_o     registered, high while locked
//   err_o        one-cycle pulse after a mismatching locked beat
//   lock_lost_o  one-cycle pulse when lock is lost
//   err_count_o  saturating count of locked mismatches
//   bit_count_o  (LFSR_CHECKER_BER_EN only) saturating count of valid
//                beats spent locked, for BER = err_count_o / bit_count_o
//
// Build option: define LFSR_CHECKER_BER_EN to add bit_count_o.
// ---------------------------------------------------------------------------
module lfsr_checker #(
    parameter int SYNC_BITS   = 64,
    parameter int WINDOW      = 256,
    parameter int LOSS_THRESH = 16,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic             bit_i,
    input  logic             valid_i,
    input  logic             clear_i,
    output logic             locked_o,
    output logic             err_o,
    output logic             lock_lost_o,
`ifdef LFSR_CHECKER_BER_EN
    output logic [31:0]      bit_count_o,
`endif
    output logic [CNT_W-1:0] err_count_o
);

    localparam int MATCH_W = $clog2(SYNC_BITS + 1);
    localparam int WB_W    = $clog2(WINDOW + 1);
    localparam int WE_W    = $clog2(LOSS_THRESH + 1);

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [31:0]          r_q, r_d;
    logic [4:0]           fill_q, fill_d;
    logic [MATCH_W-1:0]   match_q, match_d;
    logic [WB_W-1:0]      wbeat_q, wbeat_d;
    logic [WE_W-1:0]      werr_q, werr_d;
    logic [CNT_W-1:0]     cnt_d;
    logic                 err_d, lost_d;
    logic                 pred, mism;
    logic [31:0]          hunt_r;

    // The MSB only ever shifts out; the feedback taps stop at bit 27.
    logic unused_r_msb;
    assign unused_r_msb = r_q[31];

    always_comb begin
        pred    = r_q[27] ^ r_q[23] ^ r_q[19] ^ r_q[18] ^ r_q[15]
                ^ r_q[11] ^ r_q[7]  ^ r_q[4]  ^ r_q[1];
        mism    = bit_i ^ pred;
        hunt_r  = {r_q[30:0], bit_i};

        state_d = state_q;
        r_d     = r_q;
        fill_d  = fill_q;
        match_d = match_q;
        wbeat_d = wbeat_q;
        werr_d  = werr_q;
        cnt_d   = err_count_o;
        err_d   = 1'b0;
        lost_d  = 1'b0;

        if (valid_i) begin
            unique case (state_q)
                HUNT: begin
                    // Load raw received bits; after 32 of them r holds the
                    // generator state, unless the line is stuck at zero.
                    r_d = hunt_r;
                    if (fill_q == 5'd31) begin
                        fill_d = 5'd0;
                        if (hunt_r != 32'd0) begin
                            state_d = VERIFY;
                            match_d = '0;
                        end
                    end else begin
                        fill_d = fill_q + 5'd1;
                    end
                end
                VERIFY: begin
                    r_d = {r_q[30:0], pred};
                    if (!mism) begin
                        if (match_q == MATCH_W'(SYNC_BITS - 1)) begin
                            state_d = LOCKED;
                            match_d = '0;
                            wbeat_d = '0;
                            werr_d  = '0;
                        end else begin
                            match_d = match_q + MATCH_W'(1);
                        end
                    end else begin
                        state_d = HUNT;
                        fill_d  = 5'd0;
                        match_d = '0;
                    end
                end
                LOCKED: begin
                    // Flywheel: r advances on its own prediction so a bad
                    // received bit never corrupts future predictions.
                    r_d = {r_q[30:0], pred};
                    if (mism) begin
                        err_d = 1'b1;
                        if (!(&err_count_o))
                            cnt_d = err_count_o + CNT_W'(1);
                    end
                    // Loss takes priority over the end-of-window clear.
                    if (mism && (werr_q == WE_W'(LOSS_THRESH - 1))) begin
                        state_d = HUNT;
                        lost_d  = 1'b1;
                        fill_d  = 5'd0;
                        match_d = '0;
                        wbeat_d = '0;
                        werr_d  = '0;
                    end else if (wbeat_q == WB_W'(WINDOW - 1)) begin
                        wbeat_d = '0;
                        werr_d  = '0;
                    end else begin
                        wbeat_d = wbeat_q + WB_W'(1);
                        werr_d  = werr_q + WE_W'(mism);
                    end
                end
                default: begin
                    state_d = HUNT;
                    fill_d  = 5'd0;
                    match_d = '0;
                end
            endcase
        end

        // Clear beats a same-cycle increment.
        if (clear_i)
            cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q     <= HUNT;
            r_q         <= '0;
            fill_q      <= '0;
            match_q     <= '0;
            wbeat_q     <= '0;
            werr_q      <= '0;
            locked_o    <= 1'b0;
            err_o       <= 1'b0;
            lock_lost_o <= 1'b0;
            err_count_o <= '0;
        end else begin
            state_q     <= state_d;
            r_q         <= r_d;
            fill_q      <= fill_d;
            match_q     <= match_d;
            wbeat_q     <= wbeat_d;
            werr_q      <= werr_d;
            locked_o    <= (state_d == LOCKED);
            err_o       <= err_d;
            lock_lost_o <= lost_d;
            err_count_o <= cnt_d;
        end
    end

`ifdef LFSR_CHECKER_BER_EN
    logic [31:0] bit_cnt_d;

    always_comb begin
        bit_cnt_d = bit_count_o;
        if (valid_i && (state_q == LOCKED) && !(&bit_count_o))
            bit_cnt_d = bit_count_o + 32'd1;
        if (clear_i)
            bit_cnt_d = '0;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni)
            bit_count_o <= '0;
        else
            bit_count_o <= bit_cnt_d;
    end
`endif

endmodule

// File: tb/tb_lfsr_checker.sv
// ---------------------------------------------------------------------------
// tb_lfsr_checker
//
// Drives PRBS streams (generator seed 123456789) with randomly placed bit
// errors into two checkers, one with CNT_W=16 and one with CNT_W=4, and
// compares every cycle against a behavioural model built from the stream
// rules: a bit history queue for hunting, a model generator for prediction,
// plain integer counters for windows and errors.
// ---------------------------------------------------------------------------
module tb_lfsr_checker;

    localparam int          SYNC = 64;
    localparam int          WIN  = 256;
    localparam int          THR  = 16;
    localparam logic [31:0] SEED = 32'd123456789;
    localparam logic [31:0] TAPS = 32'h088C_8892;  // bits 27,23,19,18,15,11,7,4,1

    localparam int M_HUNT = 0, M_VERIFY = 1, M_LOCKED = 2;

    logic        clk_i = 1'b0;
    logic        reset_ni = 1'b1;
    logic        bit_i = 1'b0;
    logic        valid_i = 1'b0;
    logic        clear_i = 1'b0;
    logic        locked_o, err_o, lock_lost_o;
    logic [15:0] err_count_o;
    logic        locked4, err4, lost4;
    logic [3:0]  cnt4;
`ifdef LFSR_CHECKER_BER_EN
    logic [31:0] bit_count_o, bits4;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk_i = ~clk_i;

    lfsr_checker dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .bit_i(bit_i), .valid_i(valid_i),
        .clear_i(clear_i), .locked_o(locked_o), .err_o(err_o),
        .lock_lost_o(lock_lost_o),
`ifdef LFSR_CHECKER_BER_EN
        .bit_count_o(bit_count_o),
`endif
        .err_count_o(err_count_o)
    );

    lfsr_checker #(.CNT_W(4)) dut4 (
        .clk_i(clk_i), .reset_ni(reset_ni), .bit_i(bit_i), .valid_i(valid_i),
        .clear_i(clear_i), .locked_o(locked4), .err_o(err4),
        .lock_lost_o(lost4),
`ifdef LFSR_CHECKER_BER_EN
        .bit_count_o(bits4),
`endif
        .err_count_o(cnt4)
    );

    // ---------------- generator and reference model ----------------
    logic [31:0] gen_s;
    int          m_mode, m_match, m_wb, m_we, m_errs;
    bit          hist[$];
    logic [31:0] m_s;
    bit          x_err, x_lost;
`ifdef LFSR_CHECKER_BER_EN
    longint      m_bits;
`endif

    function automatic logic fb(input logic [31:0] s);
        return ^(s & TAPS);
    endfunction

    task automatic gen(output logic b);
        b = fb(gen_s);
        gen_s = {gen_s[30:0], b};
    endtask

    task automatic model(input logic b, input logic v, input logic c);
        logic        e;
        logic [31:0] seed;
        x_err  = 1'b0;
        x_lost = 1'b0;
        if (v) begin
            case (m_mode)
                M_HUNT: begin
                    hist.push_back(b);
                    if (hist.size() == 32) begin
                        seed = '0;
                        foreach (hist[i]) seed = {seed[30:0], hist[i]};
                        hist.delete();
                        if (seed != 0) begin
                            m_mode  = M_VERIFY;
                            m_s     = seed;
                            m_match = 0;
                        end
                    end
                end
                M_VERIFY: begin
                    e   = fb(m_s);
                    m_s = {m_s[30:0], e};
                    if (b == e) begin
                        m_match++;
                        if (m_match == SYNC) begin
                            m_mode = M_LOCKED;
                            m_wb   = 0;
                            m_we   = 0;
                        end
                    end else begin
                        m_mode = M_HUNT;
                    end
                end
                default: begin
                    e   = fb(m_s);
                    m_s = {m_s[30:0], e};
                    m_wb++;
`ifdef LFSR_CHECKER_BER_EN
                    m_bits++;
`endif
                    if (b != e) begin
                        x_err = 1'b1;
                        m_errs++;
                        m_we++;
                    end
                    if (m_we >= THR) begin
                        m_mode = M_HUNT;
                        x_lost = 1'b1;
                    end else if (m_wb == WIN) begin
                        m_wb = 0;
                        m_we = 0;
                    end
                end
            endcase
        end
        if (c) begin
            m_errs = 0;
`ifdef LFSR_CHECKER_BER_EN
            m_bits = 0;
`endif
        end
    endtask

    function automatic logic [25:0] expv();
        logic lk;
        lk = (m_mode == M_LOCKED);
        return {lk, x_err, x_lost, 16'(m_errs > 65535 ? 65535 : m_errs),
                lk, x_err, x_lost, 4'(m_errs > 15 ? 15 : m_errs)};
    endfunction

    function automatic logic [25:0] obs();
        return {locked_o, err_o, lock_lost_o, err_count_o,
                locked4, err4, lost4, cnt4};
    endfunction

    // Asserts reset, resets the model, returns with reset still low.
    task automatic apply_reset();
        reset_ni = 1'b0;
        bit_i    = 1'b0;
        valid_i  = 1'b0;
        clear_i  = 1'b0;
        m_mode   = M_HUNT;
        hist.delete();
        m_errs   = 0;
        x_err    = 1'b0;
        x_lost   = 1'b0;
`ifdef LFSR_CHECKER_BER_EN
        m_bits   = 0;
`endif
        #1;
    endtask

    // One clock: drive inputs, advance model on the edge, settle 1 time unit.
    task automatic step(input logic b, input logic v, input logic c);
        bit_i   = b;
        valid_i = v;
        clear_i = c;
        @(posedge clk_i);
        model(b, v, c);
        #1;
    endtask

    // Random choice that places exactly `need` errors in `remaining` beats.
    function automatic bit pick(input int need, input int remaining);
        return (need > 0) && ($urandom_range(remaining - 1, 0) < need);
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        #3;
        apply_reset();
        if (obs() !== 26'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h exp 0", obs());
        end
        checks++;
        reset_ni = 1'b1;
        step(1'b1, 1'b0, 1'b0);
        if (obs() !== expv()) begin
            errors++;
            $display("FAIL idle_after_reset got %h exp %h", obs(), expv());
        end
        checks++;
    endtask

    task automatic lock_clean(input string tag);
        logic b;
        gen_s = SEED;
        for (int i = 1; i <= 96; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL %s_trace beat %0d got %h exp %h", tag, i, obs(), expv());
            end
            if (locked_o !== (i == 96)) begin
                errors++;
                $display("FAIL %s_lock_time beat %0d locked %b", tag, i, locked_o);
            end
            checks += 2;
        end
    endtask

    task automatic test_clean_lock();
        apply_reset();
        reset_ni = 1'b1;
        lock_clean("clean");
        if (err_count_o !== 16'd0) begin
            errors++;
            $display("FAIL clean_count got %0d exp 0", err_count_o);
        end
        checks++;
    endtask

    task automatic test_single_error();
        logic b;
        gen(b);
        step(~b, 1'b1, 1'b0);
        if ({err_o, locked_o, err_count_o} !== {1'b1, 1'b1, 16'd1}) begin
            errors++;
            $display("FAIL single_err got err=%b lk=%b cnt=%0d exp 1 1 1",
                     err_o, locked_o, err_count_o);
        end
        checks++;
        for (int i = 0; i < 300; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (obs() !== expv() || err_o !== 1'b0) begin
                errors++;
                $display("FAIL single_tail beat %0d got %h exp %h", i, obs(), expv());
            end
            checks++;
        end
        if (err_count_o !== 16'd1) begin
            errors++;
            $display("FAIL single_count got %0d exp 1", err_count_o);
        end
        checks++;
    endtask

    task automatic test_loss();
        logic b;
        int   made, j;
        apply_reset();
        reset_ni = 1'b1;
        lock_clean("loss_lock");
        made = 0;
        j    = 0;
        while (made < THR && j < WIN) begin
            gen(b);
            if (pick(THR - made, WIN - j)) begin
                b = ~b;
                made++;
            end
            step(b, 1'b1, 1'b0);
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL loss_trace beat %0d got %h exp %h", j, obs(), expv());
            end
            checks++;
            j++;
        end
        if ({lock_lost_o, locked_o, err_count_o} !== {1'b1, 1'b0, 16'd16}) begin
            errors++;
            $display("FAIL loss_event got lost=%b lk=%b cnt=%0d exp 1 0 16",
                     lock_lost_o, locked_o, err_count_o);
        end
        checks++;
        for (int i = 1; i <= 96; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
            if (obs() !== expv() || locked_o !== (i == 96)) begin
                errors++;
                $display("FAIL relock beat %0d got %h exp %h", i, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_two_windows();
        logic b;
        int   made;
        apply_reset();
        reset_ni = 1'b1;
        lock_clean("win_lock");
        made = 0;
        for (int j = 0; j < 2 * WIN; j++) begin
            if (j == WIN) made = 0;
            gen(b);
            if (pick(15 - made, WIN - (j % WIN))) begin
                b = ~b;
                made++;
            end
            step(b, 1'b1, 1'b0);
            if (obs() !== expv() || lock_lost_o !== 1'b0) begin
                errors++;
                $display("FAIL window_trace beat %0d got %h exp %h", j, obs(), expv());
            end
            checks++;
        end
        if ({locked_o, err_count_o} !== {1'b1, 16'd30}) begin
            errors++;
            $display("FAIL window_count got lk=%b cnt=%0d exp 1 30", locked_o, err_count_o);
        end
        checks++;
    endtask

    task automatic test_zero_stream();
        apply_reset();
        reset_ni = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step(1'b0, 1'b1, 1'b0);
            if (obs() !== expv() || locked_o !== 1'b0) begin
                errors++;
                $display("FAIL zero_stream beat %0d got %h exp %h", i, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_valid_toggle();
        logic b;
        logic v;
        int   nvalid;
        apply_reset();
        reset_ni = 1'b1;
        gen_s  = SEED;
        nvalid = 0;
        for (int cyc = 1; cyc <= 192; cyc++) begin
            v = cyc[0];
            if (v) begin
                gen(b);
                nvalid++;
            end else begin
                b = 1'($urandom);
            end
            step(b, v, 1'b0);
            if (obs() !== expv() || locked_o !== (nvalid == 96)) begin
                errors++;
                $display("FAIL toggle cyc %0d got %h exp %h", cyc, obs(), expv());
            end
            checks++;
        end
    endtask

    task automatic test_saturate();
        logic b;
        int   made;
        apply_reset();
        reset_ni = 1'b1;
        lock_clean("sat_lock");
        made = 0;
        for (int j = 0; j < 2 * WIN; j++) begin
            if (j == WIN) made = 0;
            gen(b);
            if (pick(10 - made, WIN - (j % WIN))) begin
                b = ~b;
                made++;
            end
            step(b, 1'b1, 1'b0);
            if (obs() !== expv()) begin
                errors++;
                $display("FAIL sat_trace beat %0d got %h exp %h", j, obs(), expv());
            end
            checks++;
        end
        if ({err_count_o, cnt4} !== {16'd20, 4'd15}) begin
            errors++;
            $display("FAIL sat_count got %0d/%0d exp 20/15", err_count_o, cnt4);
        end
        checks++;
`ifdef LFSR_CHECKER_BER_EN
        if (bit_count_o !== 32'd512) begin
            errors++;
            $display("FAIL ber_bits got %0d exp 512", bit_count_o);
        end
        checks++;
`endif
        gen(b);
        step(~b, 1'b1, 1'b1);
        if ({err_o, err_count_o, cnt4} !== {1'b1, 16'd0, 4'd0} || obs() !== expv()) begin
            errors++;
            $display("FAIL clear_on_err got err=%b cnt=%0d/%0d exp 1 0/0",
                     err_o, err_count_o, cnt4);
        end
        checks++;
`ifdef LFSR_CHECKER_BER_EN
        if (bit_count_o !== 32'd0) begin
            errors++;
            $display("FAIL ber_clear got %0d exp 0", bit_count_o);
        end
        checks++;
`endif
        for (int i = 0; i < 4; i++) begin
            gen(b);
            step(b, 1'b1, 1'b0);
        end
        if (locked_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_lock got %b exp 1", locked_o);
        end
        checks++;
        #2;
        apply_reset();
        if (obs() !== 26'd0) begin
            errors++;
            $display("FAIL midop_reset got %h exp 0", obs());
        end
        checks++;
        reset_ni = 1'b1;
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_single_error();
        test_loss();
        test_two_windows();
        test_zero_stream();
        test_valid_toggle();
        test_saturate();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
